// File: rtl/alb_ctl.sv
`default_nettype none
// ============================================================================
// Module   : alb_ctl
// Purpose  : Sequencing controller for an external arithmetic/logic block
//            (ALB). Owns a 4 x 10-bit register file and a {C,V,N,Z} flag
//            register, and steps each instruction through
//            IDLE -> LOAD -> EXEC -> WB -> IDLE.
// Ports    : CLK, RST            clock, asynchronous active-high reset
//            START, INSTR        instruction issue {OP,RD,RA,RB,USE_C}
//            BUSY, DONE          in-flight indication, writeback pulse
//            WE, WADDR, WDATA    external register write (IDLE only)
//            RADDR, RDATA        combinational register read
//            ALB_A/B/CI/MI       registered operands and mode to the ALB
//            ALB_F/CO/VO/NO/ZO   combinational result from the ALB
//            FLAGS               registered {C,V,N,Z}
// Revision : 1.0 - initial release
// ============================================================================
module alb_ctl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [9:0] INSTR,
    output logic       BUSY,
    output logic       DONE,
    input  logic       WE,
    input  logic [1:0] WADDR,
    input  logic [9:0] WDATA,
    input  logic [1:0] RADDR,
    output logic [9:0] RDATA,
    output logic [9:0] ALB_A,
    output logic [9:0] ALB_B,
    output logic       ALB_CI,
    output logic [2:0] ALB_MI,
    input  logic [9:0] ALB_F,
    input  logic       ALB_CO,
    input  logic       ALB_VO,
    input  logic       ALB_NO,
    input  logic       ALB_ZO,
    output logic [3:0] FLAGS
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam int C_FLAG_C = 3;

    logic [1:0] r_state;
    logic [9:0] r_instr;
    logic [9:0] r_regs [4];
    logic [9:0] r_res;
    logic [3:0] r_res_flags;
    logic [3:0] r_flags;
    logic [9:0] r_alb_a;
    logic [9:0] r_alb_b;
    logic       r_alb_ci;
    logic [2:0] r_alb_mi;
    logic       r_done;

    // Fields of the instruction captured in IDLE
    logic [2:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_ra;
    logic [1:0] w_rb;
    logic       w_use_c;

    assign w_op    = r_instr[9:7];
    assign w_rd    = r_instr[6:5];
    assign w_ra    = r_instr[4:3];
    assign w_rb    = r_instr[2:1];
    assign w_use_c = r_instr[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_res       <= '0;
            r_res_flags <= '0;
            r_flags     <= '0;
            r_alb_a     <= '0;
            r_alb_b     <= '0;
            r_alb_ci    <= 1'b0;
            r_alb_mi    <= '0;
            r_done      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // DONE is a single-cycle pulse; only WB re-arms it
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A write and a start on the same edge both land; the
                    // following LOAD therefore sees the freshly written value.
                    if (WE) begin
                        r_regs[WADDR] <= WDATA;
                    end
                    if (START) begin
                        r_instr <= INSTR;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_alb_a  <= r_regs[w_ra];
                    r_alb_b  <= r_regs[w_rb];
                    r_alb_mi <= w_op;
                    r_alb_ci <= w_use_c & r_flags[C_FLAG_C];
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_res       <= ALB_F;
                    r_res_flags <= {ALB_CO, ALB_VO, ALB_NO, ALB_ZO};
                    r_state     <= S_WB;
                end
                S_WB: begin
                    r_regs[w_rd] <= r_res;
                    r_flags      <= r_res_flags;
                    r_done       <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // BUSY decodes straight from the state register so it drops together
    // with the asynchronous reset.
    assign BUSY   = (r_state != S_IDLE);
    assign DONE   = r_done;
    assign RDATA  = r_regs[RADDR];
    assign ALB_A  = r_alb_a;
    assign ALB_B  = r_alb_b;
    assign ALB_CI = r_alb_ci;
    assign ALB_MI = r_alb_mi;
    assign FLAGS  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alb_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alb_ctl
// Purpose  : Self-checking bench for alb_ctl with a behavioural ALB attached
//            (000 add, 001 sub, 010 and, 011 or, 100 xor, others pass A).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alb_ctl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [9:0] INSTR;
    logic       BUSY;
    logic       DONE;
    logic       WE;
    logic [1:0] WADDR;
    logic [9:0] WDATA;
    logic [1:0] RADDR;
    logic [9:0] RDATA;
    logic [9:0] ALB_A;
    logic [9:0] ALB_B;
    logic       ALB_CI;
    logic [2:0] ALB_MI;
    logic [9:0] ALB_F;
    logic       ALB_CO;
    logic       ALB_VO;
    logic       ALB_NO;
    logic       ALB_ZO;
    logic [3:0] FLAGS;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alb_ctl dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .INSTR  (INSTR),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .WE     (WE),
        .WADDR  (WADDR),
        .WDATA  (WDATA),
        .RADDR  (RADDR),
        .RDATA  (RDATA),
        .ALB_A  (ALB_A),
        .ALB_B  (ALB_B),
        .ALB_CI (ALB_CI),
        .ALB_MI (ALB_MI),
        .ALB_F  (ALB_F),
        .ALB_CO (ALB_CO),
        .ALB_VO (ALB_VO),
        .ALB_NO (ALB_NO),
        .ALB_ZO (ALB_ZO),
        .FLAGS  (FLAGS)
    );

    // Behavioural ALB
    logic [10:0] w_sum;
    logic [9:0]  w_f;
    logic        w_co;
    logic        w_vo;

    always_comb begin
        w_sum = '0;
        w_f   = ALB_A;
        w_co  = 1'b0;
        w_vo  = 1'b0;
        case (ALB_MI)
            3'b000: begin
                w_sum = {1'b0, ALB_A} + {1'b0, ALB_B} + {10'd0, ALB_CI};
                w_f   = w_sum[9:0];
                w_co  = w_sum[10];
                w_vo  = (ALB_A[9] == ALB_B[9]) && (w_f[9] != ALB_A[9]);
            end
            3'b001: begin
                w_sum = {1'b0, ALB_A} + {1'b0, ~ALB_B} + 11'd1;
                w_f   = w_sum[9:0];
                w_co  = w_sum[10];
                w_vo  = (ALB_A[9] != ALB_B[9]) && (w_f[9] != ALB_A[9]);
            end
            3'b010:  w_f = ALB_A & ALB_B;
            3'b011:  w_f = ALB_A | ALB_B;
            3'b100:  w_f = ALB_A ^ ALB_B;
            default: w_f = ALB_A;
        endcase
    end

    assign ALB_F  = w_f;
    assign ALB_CO = w_co;
    assign ALB_VO = w_vo;
    assign ALB_NO = w_f[9];
    assign ALB_ZO = (w_f == 10'd0);

    typedef struct {
        logic [1:0] ra;
        logic [1:0] rb;
        logic [9:0] va;
        logic [9:0] vb;
        logic [9:0] instr;
        logic       exp_ci;
        logic [9:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [9:0] d);
        WE    = 1'b1;
        WADDR = a;
        WDATA = d;
        @(negedge CLK);
        WE    = 1'b0;
    endtask

    // Loads operands, issues one instruction and checks every stage of it.
    task automatic run_vec(input vec_t v, input string tag);
        do_write(v.ra, v.va);
        do_write(v.rb, v.vb);
        START = 1'b1;
        INSTR = v.instr;
        RADDR = v.instr[6:5];
        @(negedge CLK);                       // edge 1: now LOAD
        START = 1'b0;
        chk({tag, "_busy_load"}, 32'(BUSY), 32'd1);
        chk({tag, "_done_load"}, 32'(DONE), 32'd0);
        @(negedge CLK);                       // edge 2: now EXEC
        chk({tag, "_alb_a"},  32'(ALB_A),  32'(v.va));
        chk({tag, "_alb_b"},  32'(ALB_B),  32'(v.vb));
        chk({tag, "_alb_ci"}, 32'(ALB_CI), 32'(v.exp_ci));
        chk({tag, "_alb_mi"}, 32'(ALB_MI), 32'(v.instr[9:7]));
        @(negedge CLK);                       // edge 3: now WB
        chk({tag, "_done_wb"}, 32'(DONE), 32'd0);
        @(negedge CLK);                       // edge 4: writeback done
        chk({tag, "_done"},  32'(DONE),  32'd1);
        chk({tag, "_busy"},  32'(BUSY),  32'd0);
        chk({tag, "_res"},   32'(RDATA), 32'(v.exp_res));
        chk({tag, "_flags"}, 32'(FLAGS), 32'(v.exp_flags));
        @(negedge CLK);
        chk({tag, "_done_off"}, 32'(DONE),  32'd0);
        chk({tag, "_a_hold"},   32'(ALB_A), 32'(v.va));
    endtask

    initial begin
        int   done_cnt;
        vec_t v;

        //           ra    rb    va             vb             instr          ci    res            flags CVNZ
        vecs[0] = '{2'd0, 2'd1, 10'b0110001110, 10'b1010010111, 10'b0001000010, 1'b0, 10'b0000100101, 4'b1000};
        vecs[1] = '{2'd0, 2'd1, 10'b0110001110, 10'b1010010111, 10'b0011100010, 1'b0, 10'b1011110111, 4'b0110};
        vecs[2] = '{2'd0, 2'd0, 10'b0110001110, 10'b0110001110, 10'b0010000000, 1'b0, 10'b0000000000, 4'b1001};
        vecs[3] = '{2'd0, 2'd1, 10'h000,        10'h000,        10'b0001000011, 1'b1, 10'b0000000001, 4'b0000};
        vecs[4] = '{2'd0, 2'd1, 10'h000,        10'h000,        10'b0001000010, 1'b0, 10'b0000000000, 4'b0001};
        vecs[5] = '{2'd0, 2'd1, 10'h000,        10'h000,        10'b0001000011, 1'b0, 10'b0000000000, 4'b0001};
        vecs[6] = '{2'd2, 2'd3, 10'h3F0,        10'h0FF,        10'b0100110110, 1'b0, 10'h0F0,        4'b0000};
        vecs[7] = '{2'd1, 2'd2, 10'h1FF,        10'h001,        10'b0000001100, 1'b0, 10'h200,        4'b0110};
        vecs[8] = '{2'd3, 2'd3, 10'h300,        10'h300,        10'b0001111110, 1'b0, 10'h200,        4'b1010};
        vecs[9] = '{2'd1, 2'd2, 10'h155,        10'h0AA,        10'b1111001101, 1'b1, 10'h155,        4'b0000};

        RST   = 1'b1;
        START = 1'b0;
        INSTR = '0;
        WE    = 1'b0;
        WADDR = '0;
        WDATA = '0;
        RADDR = '0;
        @(negedge CLK);
        @(negedge CLK);

        // Reset state
        chk("rst_busy",  32'(BUSY),   32'd0);
        chk("rst_done",  32'(DONE),   32'd0);
        chk("rst_flags", 32'(FLAGS),  32'd0);
        chk("rst_a",     32'(ALB_A),  32'd0);
        chk("rst_b",     32'(ALB_B),  32'd0);
        chk("rst_ci",    32'(ALB_CI), 32'd0);
        chk("rst_mi",    32'(ALB_MI), 32'd0);
        for (int r = 0; r < 4; r++) begin
            RADDR = 2'(r);
            #1;
            chk($sformatf("rst_reg%0d", r), 32'(RDATA), 32'd0);
        end
        RST = 1'b0;
        @(negedge CLK);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // START and WE while busy must be ignored
        do_write(2'd0, 10'd5);
        do_write(2'd1, 10'd3);
        do_write(2'd2, 10'h111);
        do_write(2'd3, 10'h222);
        START = 1'b1;
        INSTR = 10'b0001000010;               // add RD=2 RA=0 RB=1
        @(negedge CLK);                       // LOAD
        INSTR = 10'b1111111111;
        WE    = 1'b1;
        WADDR = 2'd3;
        WDATA = 10'h3FF;
        @(negedge CLK);                       // EXEC
        chk("bp_alb_a",  32'(ALB_A),  32'd5);
        chk("bp_alb_mi", 32'(ALB_MI), 32'd0);
        @(negedge CLK);                       // WB
        START    = 1'b0;
        WE       = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
        end
        chk("bp_done_cnt", 32'(done_cnt), 32'd1);
        chk("bp_busy",     32'(BUSY),     32'd0);
        RADDR = 2'd0; #1; chk("bp_reg0", 32'(RDATA), 32'd5);
        RADDR = 2'd1; #1; chk("bp_reg1", 32'(RDATA), 32'd3);
        RADDR = 2'd2; #1; chk("bp_reg2", 32'(RDATA), 32'd8);
        RADDR = 2'd3; #1; chk("bp_reg3", 32'(RDATA), 32'h222);
        chk("bp_flags", 32'(FLAGS), 32'd0);

        // Leave non-zero flags behind so the reset clearing is visible
        v = '{2'd2, 2'd3, 10'h3FF, 10'h001, 10'b0000110110, 1'b0, 10'h000, 4'b1001};
        run_vec(v, "pre_rst");

        // Reset in EXEC aborts the instruction
        do_write(2'd0, 10'd5);
        do_write(2'd1, 10'd3);
        START = 1'b1;
        INSTR = 10'b0011000010;               // sub RD=2 RA=0 RB=1
        RADDR = 2'd0;
        @(negedge CLK);                       // LOAD
        START = 1'b0;
        @(negedge CLK);                       // EXEC
        RST = 1'b1;
        #1;
        chk("mr_busy",  32'(BUSY),   32'd0);
        chk("mr_done",  32'(DONE),   32'd0);
        chk("mr_a",     32'(ALB_A),  32'd0);
        chk("mr_b",     32'(ALB_B),  32'd0);
        chk("mr_mi",    32'(ALB_MI), 32'd0);
        chk("mr_flags", 32'(FLAGS),  32'd0);
        chk("mr_reg0",  32'(RDATA),  32'd0);
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
        end
        chk("mr_no_done", 32'(done_cnt), 32'd0);

        // First START after reset release is taken on the next edge
        RST   = 1'b0;
        START = 1'b1;
        INSTR = 10'b0001100010;               // add RD=3 RA=0 RB=1 on cleared regs
        RADDR = 2'd3;
        @(negedge CLK);
        START = 1'b0;
        chk("ar_busy", 32'(BUSY), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        chk("ar_done",  32'(DONE),  32'd1);
        chk("ar_res",   32'(RDATA), 32'd0);
        chk("ar_flags", 32'(FLAGS), 32'b0001);
        @(negedge CLK);

        v = '{2'd0, 2'd1, 10'd7, 10'd2, 10'b0001100010, 1'b0, 10'd9, 4'b0000};
        run_vec(v, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alb_ctl.md
ALB_CTL -- requirements
Module: alb_ctl

Interface
REQ-001 SHALL have port CLK  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port START  in  1  instruction valid; sampled only in IDLE.
REQ-004 SHALL have port INSTR  in  10  {OP[9:7], RD[6:5], RA[4:3], RB[2:1], USE_C[0]}.
REQ-005 SHALL have port BUSY  out  1  high while an instruction is in flight; upstream may issue only when low.
REQ-006 SHALL have port DONE  out  1  one-cycle pulse at writeback.
REQ-007 SHALL have port WE  in  1  external register write strobe.
REQ-008 SHALL have port WADDR  in  2  external write address.
REQ-009 SHALL have port WDATA  in  10  external write data.
REQ-010 SHALL have port RADDR  in  2  external read address.
REQ-011 SHALL have port RDATA  out  10  combinational read of REG[RADDR].
REQ-012 SHALL have ports ALB_A, ALB_B  out  10 each  registered operands to downstream ALB.
REQ-013 SHALL have ports ALB_CI  out  1 and ALB_MI  out  3  registered carry-in and mode to ALB.
REQ-014 SHALL have ports ALB_F  in  10 and ALB_CO, ALB_VO, ALB_NO, ALB_ZO  in  1 each  combinational ALB result.
REQ-015 SHALL have port FLAGS  out  4  registered {C,V,N,Z}.

Function
REQ-016 SHALL contain register file REG[0..3], 10 bits each.
REQ-017 SHALL implement FSM IDLE -> LOAD -> EXEC -> WB -> IDLE; each non-IDLE state lasts exactly one cycle.
REQ-018 IDLE: on edge with START=1, SHALL latch INSTR and go to LOAD; START=0 stays IDLE.
REQ-019 LOAD: SHALL register ALB_A<=REG[RA], ALB_B<=REG[RB], ALB_MI<=OP, ALB_CI<=(USE_C ? FLAGS.C : 0); go to EXEC.
REQ-020 EXEC: SHALL latch ALB_F and the four ALB flags into an internal result register; go to WB.
REQ-021 WB: SHALL write REG[RD]<=result, FLAGS<={CO,VO,NO,ZO} captured in EXEC; go to IDLE.
REQ-022 DONE SHALL be registered, high for exactly the one cycle following the WB edge.
REQ-023 BUSY SHALL be high in LOAD, EXEC and WB, low in IDLE; START-to-DONE latency is 4 edges.
REQ-024 START while BUSY SHALL be ignored; no queueing.
REQ-025 WE SHALL write REG[WADDR]<=WDATA only in IDLE; WE while BUSY SHALL be ignored.
REQ-026 WE and START on the same IDLE edge: both SHALL take effect; the LOAD that follows reads the new value.
REQ-027 ALB_A/B/CI/MI SHALL hold their values from LOAD until the next LOAD.
REQ-028 OP SHALL be passed to ALB_MI unmodified; the block is opcode-agnostic.
REQ-029 RD equal to RA or RB SHALL be legal; operands are those read in LOAD.
REQ-030 FLAGS and REG SHALL change only in WB (REG also via REQ-025).

Reset
REQ-031 RST high SHALL immediately force state IDLE and clear REG[0..3], FLAGS, the result register, ALB_A, ALB_B, ALB_CI, ALB_MI and DONE to 0; BUSY SHALL be 0.
REQ-032 RST asserted mid-instruction SHALL abort it: no REG/FLAGS write and no DONE pulse.
REQ-033 After RST deasserts, the first START SHALL be accepted on the next rising edge.

Verification (bench instantiates alb_ctl wired to the real ALB)
REQ-034 Add: REG0=0110001110, REG1=1010010111, INSTR OP=000 RD=2 RA=0 RB=1 USE_C=0 -> REG2=0000100101, FLAGS C=1 V=0 N=0 Z=0, DONE 4 edges after START.
REQ-035 Sub: same operands, OP=001 RD=3 -> REG3=1011110111, N=1, V=1, Z=0; FLAGS.C equals ALB_CO sampled in EXEC.
REQ-036 Zero: OP=001 RA=RB=0 RD=0 -> REG0=0000000000, Z=1, N=0.
REQ-037 Carry chain: after REQ-034 (C=1), REG0=0, REG1=0, OP=000 USE_C=1 -> ALB_CI=1 in EXEC and result 0000000001; same with USE_C=0 -> 0000000000.
REQ-038 Busy protection: START and WE pulsed during LOAD/EXEC -> ignored; REG contents unchanged except RD; exactly one DONE.
REQ-039 Reset mid-op: RST asserted in EXEC -> outputs 0 within the same cycle, no DONE; next START completes normally.
